// File: rtl/grid_loader.sv
// Grid RAM writer: takes the puzzle text as a byte stream, checks row widths,
// writes cells row-major from address 0 and finishes with an EOT (0x04) byte.
package AocPkg;
  typedef logic [14:0] RamAddr_t;
endpackage

module grid_loader #(
  parameter int GRID_COLUMNS = 138,
  parameter int MAX_ROWS     = 138
) (
  input  logic              Clk,
  input  logic              RstN,
  input  logic              InValid,
  output logic              InReady,
  input  logic [7:0]        InData,
  input  logic              InLast,
  output AocPkg::RamAddr_t  WriteAddr,
  output logic              WriteEnable,
  output logic [7:0]        WriteData,
  output logic [15:0]       RowCount,
  output logic              Done,
  output logic              Error
);

  localparam int COL_W = $clog2(GRID_COLUMNS + 1);
  localparam logic [COL_W-1:0] COL_FULL  = COL_W'(GRID_COLUMNS);
  localparam logic [COL_W-1:0] COL_ZERO  = {COL_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE   = COL_W'(1);
  localparam AocPkg::RamAddr_t ADDR_LIMIT = AocPkg::RamAddr_t'(MAX_ROWS * GRID_COLUMNS);
  localparam AocPkg::RamAddr_t ADDR_ONE   = AocPkg::RamAddr_t'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TERM  = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [COL_W-1:0] col_r, col_s;
  AocPkg::RamAddr_t addr_r, addr_s;
  logic [15:0]      rows_r, rows_s;
  logic             we_r, we_s;
  AocPkg::RamAddr_t waddr_r, waddr_s;
  logic [7:0]       wdata_r, wdata_s;
  logic             ready_r;
  logic             done_r;
  logic             error_r;
  logic             accept_s;
  logic             eoi_s;
  logic             fault_s;

  assign InReady     = ready_r;
  assign WriteEnable = we_r;
  assign WriteAddr   = waddr_r;
  assign WriteData   = wdata_r;
  assign RowCount    = rows_r;
  assign Done        = done_r;
  assign Error       = error_r;

  // Next-state, byte classification and the next write strobe.
  always_comb begin
    state_s  = state_r;
    col_s    = col_r;
    addr_s   = addr_r;
    rows_s   = rows_r;
    we_s     = 1'b0;
    waddr_s  = waddr_r;
    wdata_s  = wdata_r;
    eoi_s    = 1'b0;
    fault_s  = 1'b0;
    accept_s = InValid && ready_r;

    case (state_r)
      S_IDLE: begin
        state_s = S_LOAD;
      end
      S_LOAD: begin
        if (accept_s) begin
          case (InData)
            8'h2E, 8'h40: begin
              if ((col_r == COL_FULL) || (addr_r == ADDR_LIMIT)) begin
                fault_s = 1'b1;
              end else begin
                we_s    = 1'b1;
                waddr_s = addr_r;
                wdata_s = InData;
                addr_s  = addr_r + ADDR_ONE;
                col_s   = col_r + COL_ONE;
              end
            end
            8'h0D: begin
              fault_s = 1'b0;
            end
            8'h0A: begin
              if (col_r == COL_FULL) begin
                rows_s = rows_r + 16'd1;
                col_s  = COL_ZERO;
              end else if (col_r != COL_ZERO) begin
                fault_s = 1'b1;
              end else begin
                col_s = COL_ZERO;
              end
            end
            8'h04: begin
              eoi_s = 1'b1;
            end
            default: begin
              fault_s = 1'b1;
            end
          endcase

          // End-of-input sees the column/row state left by this same byte.
          if (fault_s) begin
            state_s = S_ERROR;
          end else if (eoi_s || InLast) begin
            if (col_s == COL_FULL) begin
              rows_s = rows_s + 16'd1;
            end else begin
              rows_s = rows_s;
            end
            if (((col_s != COL_ZERO) && (col_s != COL_FULL)) || (rows_s == 16'd0)) begin
              state_s = S_ERROR;
            end else begin
              state_s = S_TERM;
            end
          end else begin
            state_s = S_LOAD;
          end
        end else begin
          state_s = S_LOAD;
        end
      end
      S_TERM: begin
        we_s    = 1'b1;
        waddr_s = addr_r;
        wdata_s = 8'h04;
        state_s = S_DONE;
      end
      S_DONE: begin
        state_s = S_DONE;
      end
      S_ERROR: begin
        state_s = S_ERROR;
      end
      default: begin
        state_s = S_ERROR;
      end
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_r <= S_IDLE;
      col_r   <= COL_ZERO;
      addr_r  <= '0;
      rows_r  <= 16'd0;
      we_r    <= 1'b0;
      waddr_r <= '0;
      wdata_r <= 8'h00;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      addr_r  <= addr_s;
      rows_r  <= rows_s;
      we_r    <= we_s;
      waddr_r <= waddr_s;
      wdata_r <= wdata_s;
      ready_r <= (state_s == S_LOAD);
      done_r  <= (state_r == S_DONE);
      error_r <= (state_s == S_ERROR);
    end
  end

endmodule

// File: tb/tb_grid_loader.sv
// Self-checking bench for grid_loader with a 3-column, 4-row grid.
module tb_grid_loader;

  localparam int GC = 3;
  localparam int MR = 4;

  typedef logic [7:0] bq_t[$];

  logic             Clk     = 1'b0;
  logic             RstN    = 1'b0;
  logic             InValid = 1'b0;
  logic             InLast  = 1'b0;
  logic [7:0]       InData  = 8'h00;
  logic             InReady;
  logic             WriteEnable;
  logic [7:0]       WriteData;
  logic [15:0]      RowCount;
  logic             Done;
  logic             Error;
  AocPkg::RamAddr_t WriteAddr;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int exp_addr[$];
  int exp_data[$];
  int log_addr[$];
  int log_data[$];
  int acc_count = 0;
  int m_rows;
  int m_acc;
  bit m_done;
  bit m_err;

  grid_loader #(.GRID_COLUMNS(GC), .MAX_ROWS(MR)) dut (
    .Clk(Clk), .RstN(RstN), .InValid(InValid), .InReady(InReady),
    .InData(InData), .InLast(InLast), .WriteAddr(WriteAddr),
    .WriteEnable(WriteEnable), .WriteData(WriteData), .RowCount(RowCount),
    .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bq_t str2q(input string str);
    bq_t q;
    for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
    return q;
  endfunction

  function automatic int qget(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  // Reference: walk the whole text, list the RAM image and the final verdict.
  function automatic void model(input bq_t s, input bit last_end);
    int col;
    int addr;
    bit eoi;
    bit is_last;
    col = 0; addr = 0;
    m_rows = 0; m_done = 1'b0; m_err = 1'b0; m_acc = 0;
    exp_addr.delete(); exp_data.delete();
    for (int i = 0; i < s.size(); i++) begin
      m_acc++;
      eoi = (s[i] == 8'h04);
      is_last = last_end && (i == s.size() - 1);
      if (s[i] == ".") begin
        if (col == GC || addr == MR * GC) m_err = 1'b1;
        else begin exp_addr.push_back(addr); exp_data.push_back(int'(s[i])); addr++; col++; end
      end else if (s[i] == "@") begin
        if (col == GC || addr == MR * GC) m_err = 1'b1;
        else begin exp_addr.push_back(addr); exp_data.push_back(int'(s[i])); addr++; col++; end
      end else if (s[i] == 8'h0A) begin
        if (col == GC) begin m_rows++; col = 0; end
        else if (col != 0) m_err = 1'b1;
      end else if (s[i] != 8'h0D && !eoi) begin
        m_err = 1'b1;
      end
      if (!m_err && (eoi || is_last)) begin
        if (col == GC) m_rows++;
        if ((col != 0 && col != GC) || m_rows == 0) m_err = 1'b1;
        else begin exp_addr.push_back(addr); exp_data.push_back(4); m_done = 1'b1; end
      end
      if (m_err || m_done) break;
    end
  endfunction

  // Cycle compare: every write against the reference image, plus timing rules.
  int seen_acc = 0;
  bit eot_prev = 1'b0;
  always @(posedge Clk) begin
    bit acc_now;
    #1;
    if (!RstN) begin
      exp_addr.delete(); exp_data.delete();
      log_addr.delete(); log_data.delete();
      eot_prev = 1'b0;
      seen_acc = acc_count;
    end else begin
      acc_now = (acc_count != seen_acc);
      seen_acc = acc_count;
      if (eot_prev) check("done_after_eot", int'(Done), 1);
      eot_prev = 1'b0;
      if (Done || Error) check("ready_low_terminal", int'(InReady), 0);
      if (WriteEnable) begin
        log_addr.push_back(int'(WriteAddr));
        log_data.push_back(int'(WriteData));
        check("write_expected", int'(exp_addr.size() > 0), 1);
        if (exp_addr.size() > 0) begin
          check("write_addr", int'(WriteAddr), exp_addr.pop_front());
          check("write_data", int'(WriteData), exp_data.pop_front());
        end
        if (WriteData == 8'h04) begin
          check("done_low_at_eot", int'(Done), 0);
          eot_prev = 1'b1;
        end else begin
          check("write_latency", int'(acc_now), 1);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    check({name, "_ready"}, int'(InReady), 0);
    check({name, "_we"}, int'(WriteEnable), 0);
    check({name, "_addr"}, int'(WriteAddr), 0);
    check({name, "_data"}, int'(WriteData), 0);
    check({name, "_rows"}, int'(RowCount), 0);
    check({name, "_done"}, int'(Done), 0);
    check({name, "_error"}, int'(Error), 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    RstN = 1'b0; InValid = 1'b0; InLast = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge Clk);
    RstN = 1'b1;
  endtask

  task automatic send(input bq_t s, input bit last_end, input bit gap,
                      output int n_acc, output bit err_after, output bit rdy_after);
    int budget;
    bit rdy;
    bit phase;
    n_acc = 0; phase = 1'b0; rdy = 1'b0;
    for (int i = 0; i < s.size(); i++) begin
      budget = 0;
      forever begin
        @(negedge Clk);
        phase = ~phase;
        if (gap && phase) begin
          InValid = 1'b0; InLast = 1'b0; rdy = 1'b0;
        end else begin
          InValid = 1'b1; InData = s[i];
          InLast = last_end && (i == s.size() - 1);
          rdy = InReady;
        end
        @(posedge Clk);
        if (rdy) break;
        budget++;
        if (budget >= 8) break;
      end
      if (!rdy) break;
      n_acc++;
      acc_count++;
    end
    @(negedge Clk);
    InValid = 1'b0; InLast = 1'b0;
    err_after = Error;
    rdy_after = InReady;
  endtask

  task automatic run_test(input string name, input bq_t s, input bit last_end,
                          input bit gap, input bit rst);
    int n;
    bit e_after;
    bit r_after;
    if (rst) do_reset();
    model(s, last_end);
    send(s, last_end, gap, n, e_after, r_after);
    check({name, "_accepted"}, n, m_acc);
    if (n == s.size()) check({name, "_error_next_cycle"}, int'(e_after), int'(m_err));
    if (m_err || m_done) check({name, "_ready_dropped"}, int'(r_after), 0);
    repeat (6) @(negedge Clk);
    check({name, "_done"}, int'(Done), int'(m_done));
    check({name, "_error"}, int'(Error), int'(m_err));
    check({name, "_rows"}, int'(RowCount), m_rows);
    check({name, "_pending_writes"}, exp_addr.size(), 0);
  endtask

  task automatic check_image(input string name, input int lit[$]);
    check({name, "_write_count"}, log_data.size(), lit.size());
    for (int i = 0; i < lit.size(); i++) begin
      check({name, "_img_data"}, qget(log_data, i), lit[i]);
      check({name, "_img_addr"}, qget(log_addr, i), i);
    end
  endtask

  initial begin
    bq_t q;
    bq_t t1;
    int nacc;
    bit ea;
    bit ra;

    t1 = str2q("@.@\n.@@\n");

    // 1: two rows, InLast on the final newline
    run_test("t1", t1, 1'b1, 1'b0, 1'b1);
    check_image("t1", '{32'h40, 32'h2E, 32'h40, 32'h2E, 32'h40, 32'h40, 32'h04});
    check("t1_lit_rows", int'(RowCount), 2);
    check("t1_lit_done", int'(Done), 1);

    // 2: CRLF, last row without newline, explicit EOT
    q = str2q("@@.\r\n..@");
    q.push_back(8'h04);
    run_test("t2", q, 1'b0, 1'b0, 1'b1);
    check_image("t2", '{32'h40, 32'h40, 32'h2E, 32'h2E, 32'h2E, 32'h40, 32'h04});
    check("t2_lit_rows", int'(RowCount), 2);

    // 3: short row
    run_test("t3", str2q("@.\n"), 1'b0, 1'b0, 1'b1);
    check_image("t3", '{32'h40, 32'h2E});
    check("t3_lit_error", int'(Error), 1);
    check("t3_lit_rows", int'(RowCount), 0);

    // 4: long row
    run_test("t4", str2q("@.@@"), 1'b0, 1'b0, 1'b1);
    check_image("t4", '{32'h40, 32'h2E, 32'h40});
    check("t4_lit_addr", int'(WriteAddr), 2);
    check("t4_lit_done", int'(Done), 0);

    // 5a: valid rows with InValid toggling
    run_test("t5a", t1, 1'b1, 1'b1, 1'b1);
    check_image("t5a", '{32'h40, 32'h2E, 32'h40, 32'h2E, 32'h40, 32'h40, 32'h04});

    // 5b: illegal byte, trailing byte must be refused
    run_test("t5b", str2q("@A@"), 1'b1, 1'b0, 1'b1);
    check("t5b_lit_error", int'(Error), 1);
    check("t5b_lit_writes", log_data.size(), 1);

    // 5c: fifth row overflows a 4-row grid on its first cell
    run_test("t5c", str2q("@@@\n@@@\n@@@\n@@@\n@@@\n"), 1'b0, 1'b0, 1'b1);
    check("t5c_lit_rows", int'(RowCount), 4);
    check("t5c_lit_writes", log_data.size(), 12);
    check("t5c_lit_error", int'(Error), 1);

    // 7: only a blank line, then end of input -> no rows
    run_test("t7", str2q("\n"), 1'b1, 1'b0, 1'b1);
    check("t7_lit_error", int'(Error), 1);
    check("t7_lit_writes", log_data.size(), 0);

    // 6: reset after four accepted bytes, then reload test 1
    do_reset();
    q = str2q("@.@\n");
    model(q, 1'b0);
    send(q, 1'b0, 1'b0, nacc, ea, ra);
    check("t6_partial_accepted", nacc, 4);
    check("t6_pre_addr", int'(WriteAddr), 2);
    check("t6_pre_rows", int'(RowCount), 1);
    RstN = 1'b0;
    #1;
    check_zero("t6_async");
    repeat (2) @(negedge Clk);
    RstN = 1'b1;
    run_test("t6_reload", t1, 1'b1, 1'b0, 1'b0);
    check_image("t6_reload", '{32'h40, 32'h2E, 32'h40, 32'h2E, 32'h40, 32'h40, 32'h04});
    check("t6_lit_rows", int'(RowCount), 2);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
